// File: rtl/store_buffer_pkg.sv
// Shared types and default sizing for the posted-write store buffer.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned SB_ADDR_W = 32;
    localparam int unsigned SB_DATA_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAINING,
        DONE,
        WAIT
    } fence_state_t;

endpackage

// File: rtl/sb_forward_match.sv
// Youngest-match search over the valid window [head, head+count) for load forwarding.
module sb_forward_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  logic [ADDR_W-1:0]        addrs [DEPTH],
    input  logic [DATA_W-1:0]        datas [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic                     read_enable,
    input  logic [ADDR_W-1:0]        read_address,
    input  logic [DATA_W-1:0]        mem_read_data,
    output logic                     hit,
    output logic [DATA_W-1:0]        read_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match written is the youngest one.
    always_comb begin
        hit       = 1'b0;
        read_data = mem_read_data;
        idx       = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (read_enable && (CNT_W'(i) < count) && (addrs[idx] == read_address)) begin
                hit       = 1'b1;
                read_data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store port and memory, with load forwarding and fence.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_write_enable,
    input  logic [ADDR_W-1:0] in_write_address,
    input  logic [DATA_W-1:0] in_write_data,
    output logic              out_write_ready,
    input  logic              in_read_enable,
    input  logic [ADDR_W-1:0] in_read_address,
    output logic [DATA_W-1:0] out_read_data,
    output logic              out_read_hit,
    output logic [ADDR_W-1:0] out_mem_read_address,
    input  logic [DATA_W-1:0] in_mem_read_data,
    output logic              out_mem_write_enable,
    output logic [ADDR_W-1:0] out_mem_write_address,
    output logic [DATA_W-1:0] out_mem_write_data,
    input  logic              in_mem_stall,
    input  logic              in_fence,
    output logic              out_fence_done,
    output logic              out_empty,
    output logic              out_overflow
);

    localparam int unsigned       PTR_W      = $clog2(DEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              fence_done;
    fence_state_t      fence_state;

    logic full;
    logic empty;
    logic ready;
    logic push;
    logic pop;

    always_comb begin
        full  = (count == FULL_COUNT);
        empty = (count == '0);
        ready = !full && (fence_state != DRAINING);
        push  = in_write_enable && ready;
        pop   = !empty && !in_mem_stall;
    end

    // Payload is not reset; validity is tracked purely by head/count.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[tail] <= in_write_address;
            data_q[tail] <= in_write_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            fence_done  <= 1'b0;
            fence_state <= IDLE;
        end else begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;

            if (push && !pop)      count <= count + CNT_ONE;
            else if (!push && pop) count <= count - CNT_ONE;

            if (in_write_enable && full) overflow <= 1'b1;

            fence_done <= 1'b0;
            case (fence_state)
                IDLE: begin
                    if (in_fence) begin
                        if (empty) begin
                            fence_state <= DONE;
                            fence_done  <= 1'b1;
                        end else begin
                            fence_state <= DRAINING;
                        end
                    end
                end
                DRAINING: begin
                    if (pop && (count == CNT_ONE)) begin
                        fence_state <= DONE;
                        fence_done  <= 1'b1;
                    end
                end
                DONE: fence_state <= WAIT;
                WAIT: begin
                    if (!in_fence) fence_state <= IDLE;
                end
                default: fence_state <= IDLE;
            endcase
        end
    end

    sb_forward_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_forward (
        .addrs         (addr_q),
        .datas         (data_q),
        .head          (head),
        .count         (count),
        .read_enable   (in_read_enable),
        .read_address  (in_read_address),
        .mem_read_data (in_mem_read_data),
        .hit           (out_read_hit),
        .read_data     (out_read_data)
    );

    always_comb begin
        out_write_ready       = ready;
        out_mem_read_address  = in_read_address;
        out_mem_write_enable  = pop;
        out_mem_write_address = addr_q[head];
        out_mem_write_data    = data_q[head];
        out_fence_done        = fence_done;
        out_empty             = empty;
        out_overflow          = overflow;
    end

endmodule
